down_counter_4: RTL and testbench

- Sequential down-counter for loop and delay control in the RISC processor.
- Complement of the existing 4-bit incrementor: it counts down instead of up.
- Loads a count, decrements once per enabled cycle through a ripple half-subtractor chain, then flags completion with a DONE/ACK handshake.
- Sits beside the program counter logic and is controlled by the instruction sequencer.

---
 rtl/down_counter_pkg.sv | 17 +
 rtl/down_counter_4_if.sv | 31 +++
 rtl/decrementor_w.sv | 37 +++
 rtl/down_counter_4.sv | 125 ++++++++++++
 tb/tb_down_counter_4.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared types and constants for the down-counter block
//
// Purpose : FSM state encoding and default counter width used by
//           down_counter_4, its interface and its testbench.
// Contents: state_t   - IDLE=2'b00, RUN=2'b01, FIN=2'b10 (2'b11 illegal)
//           DEFAULT_WIDTH - default counter width (4)
package down_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter_4_if.sv
// rtl/down_counter_4_if.sv - sequencer <-> down-counter control/status bundle
//
// Purpose : groups the load/start/hold/ack controls and the count/busy/done
//           status of down_counter_4 into one port.
// Signals : LOAD, LD_VAL[WIDTH], START, HOLD, ACK  (sequencer -> counter)
//           CNT[WIDTH], BUSY, DONE                (counter -> sequencer)
// Modports: master - sequencer side, slave - counter side
interface down_counter_4_if #(
   parameter int WIDTH = 4
);

   logic             LOAD;
   logic [WIDTH-1:0] LD_VAL;
   logic             START;
   logic             HOLD;
   logic             ACK;
   logic [WIDTH-1:0] CNT;
   logic             BUSY;
   logic             DONE;

   modport master (
      output LOAD, LD_VAL, START, HOLD, ACK,
      input  CNT, BUSY, DONE
   );

   modport slave (
      input  LOAD, LD_VAL, START, HOLD, ACK,
      output CNT, BUSY, DONE
   );

endinterface

// File: rtl/decrementor_w.sv
// rtl/decrementor_w.sv - combinational ripple decrementor built from nand gates
//
// Purpose : DIF = IN - 1 via a chain of half-subtractors, borrow-in fixed at 1.
// Ports   : IN[WIDTH]   operand
//           DIF[WIDTH]  IN minus one (wraps to all ones for IN=0)
//           BOUT        borrow out of the top stage (1 only when IN=0)
module decrementor_w #(
   parameter int WIDTH = 4
) (
   output wire [WIDTH-1:0] DIF,
   output wire             BOUT,
   input  wire [WIDTH-1:0] IN
);

   // w_b[i] is the borrow into stage i; stage 0 always borrows one.
   wire [WIDTH:0] w_b;
   assign w_b[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i = i + 1) begin : g_hs
         wire w_n1, w_n2, w_n3, w_na, w_t;
         // difference = IN[i] xor borrow, four-nand xor
         nand (w_n1, IN[i], w_b[i]);
         nand (w_n2, IN[i], w_n1);
         nand (w_n3, w_b[i], w_n1);
         nand (DIF[i], w_n2, w_n3);
         // borrow out = ~IN[i] & borrow
         nand (w_na, IN[i], IN[i]);
         nand (w_t, w_na, w_b[i]);
         nand (w_b[i+1], w_t, w_t);
      end
   endgenerate

   assign BOUT = w_b[WIDTH];

endmodule

// File: rtl/down_counter_4.sv
// rtl/down_counter_4.sv - loadable down-counter with DONE/ACK handshake
//
// Purpose : loads a count in IDLE, decrements once per non-held cycle in RUN,
//           then raises DONE in FIN until acknowledged.
// Ports   : CLK    - system clock, rising edge
//           RST_N  - asynchronous active-low reset
//           cnt_if - down_counter_4_if.slave (LOAD, LD_VAL, START, HOLD, ACK in;
//                    CNT, BUSY, DONE out, all registered)
// Option  : DOWN_COUNTER_AUTO_RELOAD_EN - reload CNT from the last loaded value
//           at the end of each pass and pulse DONE instead of stopping; ACK in
//           RUN then returns to IDLE.
module down_counter_4
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic              CLK,
   input logic              RST_N,
   down_counter_4_if.slave  cnt_if
);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic             r_busy, r_done;
   logic             w_busy_nxt, w_done_nxt;
   logic             w_pulse;
   logic [WIDTH-1:0] w_dif;
   logic             w_bout_unused;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] r_reload, w_reload_nxt;
`endif

   decrementor_w #(.WIDTH(WIDTH)) u_dec (
      .DIF  (w_dif),
      .BOUT (w_bout_unused),
      .IN   (r_cnt)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         r_reload <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         r_reload <= w_reload_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_pulse      = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      w_reload_nxt = r_reload;
`endif
      case (r_state)
         IDLE: begin
            // LOAD wins over START; a START in the same cycle is dropped.
            if (cnt_if.LOAD) begin
               w_cnt_nxt    = cnt_if.LD_VAL;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
               w_reload_nxt = cnt_if.LD_VAL;
`endif
            end else if (cnt_if.START) begin
               w_state_nxt = (r_cnt != '0) ? RUN : FIN;
            end
         end
         RUN: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            // Free-running mode can only be left by ACK; count is kept.
            if (cnt_if.ACK && (r_reload != '0))
               w_state_nxt = IDLE;
            else
`endif
            if (!cnt_if.HOLD) begin
               if (r_cnt == WIDTH'(1)) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                  if (r_reload != '0) begin
                     w_cnt_nxt = r_reload;
                     w_pulse   = 1'b1;
                  end else begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = FIN;
                  end
`else
                  w_cnt_nxt   = '0;
                  w_state_nxt = FIN;
`endif
               end else begin
                  w_cnt_nxt = w_dif;
               end
            end
         end
         FIN: begin
            if (cnt_if.ACK)
               w_state_nxt = IDLE;
         end
         default: begin
            // Illegal code 2'b11 falls back to IDLE.
            w_state_nxt = IDLE;
         end
      endcase

      // Status flags are registered copies of the next state so no input
      // reaches an output combinationally.
      w_busy_nxt = (w_state_nxt == RUN);
      w_done_nxt = (w_state_nxt == FIN) | w_pulse;
   end

   assign cnt_if.CNT  = r_cnt;
   assign cnt_if.BUSY = r_busy;
   assign cnt_if.DONE = r_done;

endmodule

// File: tb/tb_down_counter_4.sv
// tb/tb_down_counter_4.sv - scoreboard bench for down_counter_4
module tb_down_counter_4;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   down_counter_4_if #(.WIDTH(4)) u_if ();

   down_counter_4 #(.WIDTH(4)) u_dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .cnt_if (u_if)
   );

   typedef struct {
      logic [3:0] cnt;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   event async_ev;

   // Monitor: status is presented every cycle; compare once per pending entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or async_ev);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (u_if.CNT !== e.cnt || u_if.BUSY !== e.busy || u_if.DONE !== e.done) begin
               n_err++;
               $display("FAIL %s: got cnt=%0d busy=%0b done=%0b, want cnt=%0d busy=%0b done=%0b",
                        e.name, u_if.CNT, u_if.BUSY, u_if.DONE, e.cnt, e.busy, e.done);
            end
         end
      end
   end

   task automatic push_exp(input logic [3:0] ec, input logic eb, input logic ed, input string nm);
      exp_t e;
      e.cnt = ec; e.busy = eb; e.done = ed; e.name = nm;
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs and queue the status expected after the next edge.
   task automatic cyc(input logic ld, input logic [3:0] v, input logic st, input logic hd,
                      input logic ak, input logic [3:0] ec, input logic eb, input logic ed,
                      input string nm);
      @(negedge clk);
      #1;
      u_if.LOAD = ld; u_if.LD_VAL = v; u_if.START = st; u_if.HOLD = hd; u_if.ACK = ak;
      push_exp(ec, eb, ed, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      u_if.LOAD = 1'b0; u_if.LD_VAL = 4'd0; u_if.START = 1'b0; u_if.HOLD = 1'b0; u_if.ACK = 1'b0;

      // reset state, START held to show it is ignored under reset
      cyc(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "reset_state");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "reset_state2");
      rst_n = 1'b1;
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "idle_after_reset");

      // load 0 then start: straight to FIN, BUSY never rises
      cyc(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, "ld0_load");
      cyc(0, 4'd0, 1, 0, 0, 4'd0, 0, 1, "ld0_fin");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "ld0_hold_done");
      cyc(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "ld0_ack");

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
      // load 4, count 4,3,2,1,0, DONE until ACK
      cyc(1, 4'd4, 0, 0, 0, 4'd4, 0, 0, "c4_load");
      cyc(0, 4'd0, 1, 0, 0, 4'd4, 1, 0, "c4_start");
      for (int i = 1; i <= 3; i++)
         cyc(0, 4'd0, 0, 0, 0, 4'(4 - i), 1, 0, "c4_count");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "c4_done");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "c4_done_held1");
      cyc(1, 4'd6, 1, 1, 0, 4'd0, 0, 1, "c4_fin_ignores_ctl");
      cyc(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "c4_ack_idle");
      cyc(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "ack_in_idle");

      // LOAD+START together: only the load takes effect
      cyc(1, 4'd9, 1, 0, 0, 4'd9, 0, 0, "c9_load_start");
      cyc(0, 4'd0, 0, 0, 0, 4'd9, 0, 0, "c9_still_idle");
      cyc(0, 4'd0, 1, 0, 0, 4'd9, 1, 0, "c9_start");
      for (int i = 1; i <= 8; i++)
         cyc(0, 4'd0, 0, 0, 0, 4'(9 - i), 1, 0, "c9_count");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "c9_done");
      cyc(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "c9_ack");

      // ACK during RUN is ignored
      cyc(1, 4'd2, 0, 0, 0, 4'd2, 0, 0, "c2_load");
      cyc(0, 4'd0, 1, 0, 0, 4'd2, 1, 0, "c2_start");
      cyc(0, 4'd0, 0, 0, 1, 4'd1, 1, 0, "c2_ack_in_run");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "c2_done");
      cyc(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "c2_ack");

      // 15 with 3 HOLD cycles and a LOAD during RUN: DONE after 18 edges
      cyc(1, 4'd15, 0, 0, 0, 4'd15, 0, 0, "c15_load");
      cyc(0, 4'd0, 1, 0, 0, 4'd15, 1, 0, "c15_start");
      for (int i = 1; i <= 5; i++)
         cyc(0, 4'd0, 0, 0, 0, 4'(15 - i), 1, 0, "c15_count_a");
      for (int i = 0; i < 3; i++)
         cyc(0, 4'd0, 0, 1, 0, 4'd10, 1, 0, "c15_hold");
      cyc(1, 4'd3, 1, 0, 0, 4'd9, 1, 0, "c15_load_in_run");
      for (int v = 8; v >= 1; v--)
         cyc(0, 4'd0, 0, 0, 0, 4'(v), 1, 0, "c15_count_b");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "c15_done");
      cyc(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, "c15_ack");
`else
      // auto reload with 3: CNT cycles 3,2,1 and DONE pulses each wrap
      cyc(1, 4'd3, 0, 0, 0, 4'd3, 0, 0, "ar_load");
      cyc(0, 4'd0, 1, 0, 0, 4'd3, 1, 0, "ar_start");
      cyc(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "ar_2a");
      cyc(0, 4'd0, 0, 0, 0, 4'd1, 1, 0, "ar_1a");
      cyc(0, 4'd0, 0, 0, 0, 4'd3, 1, 1, "ar_pulse_a");
      cyc(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "ar_2b");
      cyc(0, 4'd0, 0, 0, 0, 4'd1, 1, 0, "ar_1b");
      cyc(0, 4'd0, 0, 1, 0, 4'd1, 1, 0, "ar_hold_at_1");
      cyc(0, 4'd0, 0, 0, 0, 4'd3, 1, 1, "ar_pulse_b");
      cyc(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "ar_2c");
      cyc(0, 4'd0, 0, 0, 1, 4'd2, 0, 0, "ar_ack_exit");
      cyc(0, 4'd0, 0, 0, 0, 4'd2, 0, 0, "ar_idle");
`endif

      // async reset mid-RUN at CNT=5
      cyc(1, 4'd7, 0, 0, 0, 4'd7, 0, 0, "ar5_load");
      cyc(0, 4'd0, 1, 0, 0, 4'd7, 1, 0, "ar5_start");
      cyc(0, 4'd0, 0, 0, 0, 4'd6, 1, 0, "ar5_6");
      cyc(0, 4'd0, 0, 0, 0, 4'd5, 1, 0, "ar5_5");
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      push_exp(4'd0, 0, 0, "async_reset_immediate");
      ->async_ev;
      cyc(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "reset_held_start");
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "reset_held");
      rst_n = 1'b1;
      cyc(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "reset_released");

      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
